// File: rtl/wbuf_sm_if.sv
// wbuf_sm_if: load/head bus of the weight buffer.
//   i_valid/i_ready/i_data : weight-load handshake (driver -> buffer)
//   adv                    : retire current head weight
//   o_valid/o_data_sign/o_data_abs/o_sat : head entry in sign-magnitude form
//   o_count                : number of valid entries
// master = weight loader / PE side, slave = the buffer.
interface wbuf_sm_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic             adv;
  logic             o_valid;
  logic             o_data_sign;
  logic [WIDTH-2:0] o_data_abs;
  logic             o_sat;
  logic [CW-1:0]    o_count;

  modport master (
    output i_valid, i_data, adv,
    input  i_ready, o_valid, o_data_sign, o_data_abs, o_sat, o_count
  );

  modport slave (
    input  i_valid, i_data, adv,
    output i_ready, o_valid, o_data_sign, o_data_abs, o_sat, o_count
  );
endinterface

// File: rtl/wbuf_sm.sv
// wbuf_sm: DEPTH-entry weight queue for the unary-temporal systolic PE.
// Weights are converted from two's complement to {sign, magnitude, sat} as
// they are loaded, so the head entry drives the PE straight from registers.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides clr)
//   clr  : synchronous flush; discards any same-cycle push/pop
//   bus  : wbuf_sm_if slave (load handshake, adv, head outputs, o_count)
module wbuf_sm #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  wbuf_sm_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry layout: [WIDTH] sign, [WIDTH-1:1] magnitude, [0] saturated flag
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_nonempty;
  logic             w_is_min;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH:0]   w_conv;
  logic [WIDTH:0]   w_head;

  assign w_nonempty  = (r_count != '0);
  assign bus.i_ready = (r_count != CW'(DEPTH));
  assign w_push      = bus.i_valid & bus.i_ready & ~clr;
  assign w_pop       = bus.adv & w_nonempty & ~clr;

  always_comb begin
    w_neg    = '0 - bus.i_data;
    w_is_min = (bus.i_data == {1'b1, {(WIDTH-1){1'b0}}});
    w_conv   = '0;
    if (!bus.i_data[WIDTH-1]) begin
      w_conv = {1'b0, bus.i_data[WIDTH-2:0], 1'b0};
    end else if (w_is_min) begin
      // -2^(WIDTH-1) has no positive counterpart; clamp and flag it
      w_conv = {1'b1, {(WIDTH-1){1'b1}}, 1'b1};
    end else begin
      w_conv = {1'b1, w_neg[WIDTH-2:0], 1'b0};
    end
  end

  // Storage has no reset: contents behind the pointers are never observed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_conv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head          = r_mem[r_rd];
  assign bus.o_valid     = w_nonempty;
  assign bus.o_data_sign = w_nonempty & w_head[WIDTH];
  assign bus.o_data_abs  = w_nonempty ? w_head[WIDTH-1:1] : '0;
  assign bus.o_sat       = w_nonempty & w_head[0];
  assign bus.o_count     = r_count;
endmodule
